// File: rtl/clk_mod_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_mod_pkg
// Description : Shared configuration, state type and pattern helper for the
//               modulated-clock decoder.
//               Frame layout: FRAME_LEN cycles, NPULSE one-cycle highs at
//               even counts 0..2*(NPULSE-1), low everywhere else.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_mod_pkg;

  localparam int FRAME_LEN   = 16;  // cycles per frame, power of two
  localparam int NPULSE      = 7;   // high pulses per frame
  localparam int GAP_MIN     = 2;   // lows that qualify as an inter-frame gap
  localparam int LOCK_FRAMES = 2;   // clean frames needed before lock
  localparam int CNT_W       = 4;   // log2(FRAME_LEN)

  // Sized forms of the above, so comparisons against CNT_W-bit registers
  // stay width-matched.
  localparam logic [CNT_W-1:0] GAP_MIN_CNT = CNT_W'(GAP_MIN);
  localparam logic [CNT_W-1:0] LOCK_CNT    = CNT_W'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0] LAST_PHASE  = CNT_W'(FRAME_LEN - 1);
  // One extra bit: 2*NPULSE may equal FRAME_LEN.
  localparam logic [CNT_W:0]   PULSE_SPAN  = (CNT_W + 1)'(2 * NPULSE);

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_e;

  // Value the generator drives at count p.
  function automatic logic expected_bit(input logic [CNT_W-1:0] p);
    return ({1'b0, p} < PULSE_SPAN) && !p[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_mod_gap_detector.sv
`default_nettype none
// ============================================================================
// Module      : clk_mod_gap_detector
// Description : Registers the incoming modulated clock and flags a start of
//               frame: a high sample preceded by at least GAP_MIN lows.
// Ports       : sysClk    in  clock, rising edge
//               sysRst    in  synchronous active-low reset
//               clkMod_i  in  modulated clock from the generator
//               din_o     out registered clkMod sample
//               sof_o     out start-of-frame flag for the din_o sample
// Revision    : 1.0 - initial release
// ============================================================================
module clk_mod_gap_detector
  import clk_mod_pkg::*;
(
  input  logic sysClk,
  input  logic sysRst,
  input  logic clkMod_i,
  output logic din_o,
  output logic sof_o
);

  logic             din_q;
  logic [CNT_W-1:0] low_run_q;
  logic [CNT_W-1:0] low_run_d;

  // Run of lows seen before the current din_q; saturating keeps it small
  // and long idle periods still qualify as a gap.
  always_comb begin
    low_run_d = low_run_q;
    if (din_q) begin
      low_run_d = '0;
    end else if (low_run_q != GAP_MIN_CNT) begin
      low_run_d = low_run_q + 1'b1;
    end
  end

  always_ff @(posedge sysClk) begin
    if (!sysRst) begin
      din_q     <= 1'b0;
      low_run_q <= '0;
    end else begin
      din_q     <= clkMod_i;
      low_run_q <= low_run_d;
    end
  end

  assign din_o = din_q;
  assign sof_o = din_q && (low_run_q == GAP_MIN_CNT);

endmodule
`default_nettype wire

// File: rtl/clk_mod_decoder.sv
`default_nettype none
// ============================================================================
// Module      : clk_mod_decoder
// Description : Receive side of the modulated-clock link. Aligns to the
//               inter-frame gap, rebuilds the generator count as phase,
//               checks every sample against the expected pattern and
//               reports lock, frame strobes and errors.
// Ports       : sysClk      in  clock, rising edge
//               sysRst      in  synchronous active-low reset
//               clkMod      in  modulated clock, synchronous to sysClk
//               phase       out recovered generator count
//               phaseValid  out phase meaningful this cycle
//               frameStrobe out pulse when phase==0 and phaseValid
//               locked      out alignment confirmed
//               errPulse    out pulse on a pattern mismatch while tracking
//               errCount    out saturating mismatch count
// Revision    : 1.0 - initial release
// ============================================================================
module clk_mod_decoder
  import clk_mod_pkg::*;
(
  input  logic             sysClk,
  input  logic             sysRst,
  input  logic             clkMod,
  output logic [CNT_W-1:0] phase,
  output logic             phaseValid,
  output logic             frameStrobe,
  output logic             locked,
  output logic             errPulse,
  output logic [7:0]       errCount
);

  logic din;
  logic sof;

  clk_mod_gap_detector u_gap (
    .sysClk   (sysClk),
    .sysRst   (sysRst),
    .clkMod_i (clkMod),
    .din_o    (din),
    .sof_o    (sof)
  );

  state_e           state_q;
  logic [CNT_W-1:0] exp_phase_q;
  logic [CNT_W-1:0] good_frames_q;

  always_ff @(posedge sysClk) begin
    if (!sysRst) begin
      state_q       <= HUNT;
      exp_phase_q   <= '0;
      good_frames_q <= '0;
      phase         <= '0;
      phaseValid    <= 1'b0;
      frameStrobe   <= 1'b0;
      locked        <= 1'b0;
      errPulse      <= 1'b0;
      errCount      <= '0;
    end else begin
      errPulse <= 1'b0;
      // Looks at the registered count, so lock follows one cycle after the
      // frame that completes the run; a mismatch below overrides it.
      locked   <= (good_frames_q == LOCK_CNT) && (state_q == TRACK);

      case (state_q)
        HUNT: begin
          if (sof) begin
            state_q     <= TRACK;
            exp_phase_q <= CNT_W'(1);
            phase       <= '0;
            phaseValid  <= 1'b1;
            frameStrobe <= 1'b1;
          end else begin
            phaseValid  <= 1'b0;
            frameStrobe <= 1'b0;
          end
        end

        TRACK: begin
          if (din == expected_bit(exp_phase_q)) begin
            phase       <= exp_phase_q;
            phaseValid  <= 1'b1;
            frameStrobe <= (exp_phase_q == '0);
            // FRAME_LEN is a power of two, so the natural wrap is mod FRAME_LEN.
            exp_phase_q <= exp_phase_q + 1'b1;
            if ((exp_phase_q == LAST_PHASE) && (good_frames_q != LOCK_CNT)) begin
              good_frames_q <= good_frames_q + 1'b1;
            end
          end else begin
            // A mismatch is never reused as a start of frame: we leave for
            // HUNT and only the next qualified gap can realign.
            errPulse      <= 1'b1;
            if (errCount != 8'hFF) begin
              errCount <= errCount + 1'b1;
            end
            phaseValid    <= 1'b0;
            frameStrobe   <= 1'b0;
            locked        <= 1'b0;
            good_frames_q <= '0;
            state_q       <= HUNT;
          end
        end

        default: state_q <= HUNT;
      endcase
    end
  end

endmodule
`default_nettype wire
